// File: rtl/gardner_ted_loop_pkg.sv
// ============================================================================
// gardner_ted_loop_pkg : shared FSM encoding, default period and saturation helpers
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package gardner_ted_loop_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_PRIME = 3'b010,
    ST_RUN   = 3'b100
  } state_e;

  localparam int DEFAULT_LAST_PERIOD = 32;

  // Symmetric clamp to +/-(2^(w-1)-1) so a later negation can never wrap.
  function automatic logic signed [63:0] sat_sym(input logic signed [63:0] x, input int w);
    logic signed [63:0] lim;
    lim = (64'sd1 <<< (w - 1)) - 64'sd1;
    if (x > lim) begin
      return lim;
    end else if (x < -lim) begin
      return -lim;
    end
    return x;
  endfunction

  function automatic logic signed [63:0] neg_sat(input logic signed [63:0] x, input int w);
    return sat_sym(-x, w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gardner_ted_loop_if.sv
// ============================================================================
// gardner_ted_loop_if : sample/strobe bus from the corrector and error return path
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface gardner_ted_loop_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] i_32m;
  logic signed [WIDTH-1:0] q_32m;
  logic signed [WIDTH-1:0] i_1m;
  logic signed [WIDTH-1:0] q_1m;
  logic                    sym_strobe;
  logic signed [WIDTH-1:0] error_n;
  logic                    err_valid;
  logic                    locked_out;

  modport master (
    output i_32m, q_32m, i_1m, q_1m, sym_strobe,
    input  error_n, err_valid, locked_out
  );

  modport slave (
    input  i_32m, q_32m, i_1m, q_1m, sym_strobe,
    output error_n, err_valid, locked_out
  );
endinterface

`default_nettype wire

// File: rtl/gardner_ted_loop_pi_filter.sv
// ============================================================================
// gardner_pi_filter : final stage - shift, integrate, saturate, negate (integrator under GARDNER_INTEGRATOR_EN)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module gardner_pi_filter
  import gardner_ted_loop_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  kp_shift_i,
  input  logic [3:0]                  ki_shift_i,
  input  logic signed [ACC_WIDTH-1:0] e_i,
  input  logic                        e_valid_i,
  output logic signed [WIDTH-1:0]     error_n_o,
  output logic                        err_valid_o
);

  logic signed [ACC_WIDTH-1:0] integ_d;
  logic signed [ACC_WIDTH:0]   v_d;
  logic signed [WIDTH-1:0]     error_n_q;
  logic signed [WIDTH-1:0]     error_n_d;
  logic                        err_valid_q;

`ifdef GARDNER_INTEGRATOR_EN
  logic signed [ACC_WIDTH-1:0] integ_q;
  logic signed [63:0]          integ_sum;

  always_comb begin
    integ_sum = 64'(e_i >>> ki_shift_i) + 64'(integ_q);
    integ_d   = ACC_WIDTH'(sat_sym(integ_sum, ACC_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      integ_q <= '0;
    end else if (e_valid_i) begin
      integ_q <= integ_d;
    end
  end
`else
  logic unused_ki;
  assign unused_ki = ^ki_shift_i;
  assign integ_d   = '0;
`endif

  // The proportional path is added to the freshly updated integrator value.
  always_comb begin
    v_d       = (ACC_WIDTH+1)'(e_i >>> kp_shift_i) + (ACC_WIDTH+1)'(integ_d);
    error_n_d = WIDTH'(neg_sat(64'(v_d), WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      error_n_q   <= '0;
      err_valid_q <= 1'b0;
    end else begin
      err_valid_q <= e_valid_i;
      if (e_valid_i) begin
        error_n_q <= error_n_d;
      end
    end
  end

  assign error_n_o   = error_n_q;
  assign err_valid_o = err_valid_q;

endmodule

`default_nettype wire

// File: rtl/gardner_ted_loop.sv
// ============================================================================
// gardner_ted_loop : Gardner TED + PI loop filter closing the symbol-timing loop (option GARDNER_INTEGRATOR_EN)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module gardner_ted_loop
  import gardner_ted_loop_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_W     = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               kp_shift_i,
  input  logic [3:0]               ki_shift_i,
  gardner_ted_loop_if.slave        bus_if
);

  localparam int               DW      = WIDTH + 1;
  localparam int               PW      = 2 * WIDTH + 1;
  localparam int               SW      = 2 * WIDTH + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        lp_q, lp_d;
  logic                    mid_ok_q, mid_ok_d;
  logic signed [WIDTH-1:0] im_q, qm_q;
  logic signed [WIDTH-1:0] ip_q, qp_q;
  state_e                  state_q;
  logic                    locked_q;
  logic                    strobe, mid_hit, timeout, start;

  assign strobe  = bus_if.sym_strobe;
  assign mid_hit = (cnt_q == (lp_q >> 1));
  assign timeout = (cnt_q == CNT_MAX);
  assign start   = strobe && (state_q == ST_RUN) && mid_ok_q;

  always_comb begin
    cnt_d    = cnt_q;
    lp_d     = lp_q;
    mid_ok_d = mid_ok_q;
    if (strobe) begin
      cnt_d    = CNT_W'(1);
      mid_ok_d = 1'b0;
      if (cnt_q >= CNT_W'(2)) begin
        lp_d = cnt_q;
      end
    end else begin
      if (!timeout) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (mid_hit) begin
        mid_ok_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      lp_q     <= CNT_W'(DEFAULT_LAST_PERIOD);
      mid_ok_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      lp_q     <= lp_d;
      mid_ok_q <= mid_ok_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!strobe && mid_hit) begin
      im_q <= bus_if.i_32m;
      qm_q <= bus_if.q_32m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      locked_q <= 1'b0;
      ip_q     <= '0;
      qp_q     <= '0;
    end else if (strobe) begin
      ip_q <= bus_if.i_1m;
      qp_q <= bus_if.q_1m;
      case (state_q)
        ST_IDLE: begin
          state_q  <= ST_PRIME;
          locked_q <= 1'b0;
        end
        ST_PRIME: begin
          if (mid_ok_q) begin
            state_q  <= ST_RUN;
            locked_q <= 1'b1;
          end
        end
        ST_RUN: begin
          locked_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end else if (timeout && (state_q != ST_IDLE)) begin
      // Lost strobes: drop lock but leave the filter output untouched.
      state_q  <= ST_IDLE;
      locked_q <= 1'b0;
    end
  end

  logic                        s1_vld_q, s2_vld_q, s3_vld_q;
  logic signed [DW-1:0]        di_q, dq_q;
  logic signed [WIDTH-1:0]     s1_im_q, s1_qm_q;
  logic signed [PW-1:0]        pi_q, pq_q;
  logic signed [SW-1:0]        sum;
  logic signed [ACC_WIDTH-1:0] e_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= start;
      s2_vld_q <= s1_vld_q;
      s3_vld_q <= s2_vld_q;
    end
  end

  assign sum = SW'(pi_q) + SW'(pq_q);

  // Each stage re-registers its operands every cycle, so overlapping strobes stay independent.
  always_ff @(posedge clk) begin
    di_q    <= DW'(ip_q) - DW'(bus_if.i_1m);
    dq_q    <= DW'(qp_q) - DW'(bus_if.q_1m);
    s1_im_q <= im_q;
    s1_qm_q <= qm_q;
    pi_q    <= PW'(s1_im_q) * PW'(di_q);
    pq_q    <= PW'(s1_qm_q) * PW'(dq_q);
    e_q     <= ACC_WIDTH'(sum >>> (WIDTH - 1));
  end

  gardner_pi_filter #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_pi_filter (
    .clk         (clk),
    .rst         (rst),
    .kp_shift_i  (kp_shift_i),
    .ki_shift_i  (ki_shift_i),
    .e_i         (e_q),
    .e_valid_i   (s3_vld_q),
    .error_n_o   (bus_if.error_n),
    .err_valid_o (bus_if.err_valid)
  );

  assign bus_if.locked_out = locked_q;

endmodule

`default_nettype wire

// File: tb/tb_gardner_ted_loop.sv
// ============================================================================
// tb_gardner_ted_loop : vector table, directed loop sequences and random stimulus vs. a reference model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_gardner_ted_loop;

  localparam int     WIDTH     = 16;
  localparam int     ACC_WIDTH = 24;
  localparam int     CNT_W     = 6;
  localparam int     CNT_MAX   = 63;
  localparam longint SAT_W     = 32767;
  localparam longint SAT_ACC   = 8388607;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] kp  = 4'd0;
  logic [3:0] ki  = 4'd15;

  gardner_ted_loop_if #(.WIDTH(WIDTH)) bus ();

  gardner_ted_loop #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .kp_shift_i (kp),
    .ki_shift_i (ki),
    .bus_if     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  int vld_count = 0;
  int d_i32 = 0, d_q32 = 0, d_i1 = 0, d_q1 = 0;

  // Reference model state
  int       m_cnt, m_lp, m_state;  // state: 0 idle, 1 prime, 2 run
  bit       m_midok, m_vld, m_lock;
  longint   m_im, m_qm, m_ip, m_qp, m_integ, m_errn;
  longint   pend_e[$];
  int       pend_t[$];

  function automatic longint clamp(input longint x, input longint lim);
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  function void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc_n, act, exp);
    end
  endfunction

  task model_step(input bit s);
    longint e, v;
    if (rst) begin
      m_cnt = 0; m_lp = 32; m_state = 0; m_midok = 0;
      m_integ = 0; m_errn = 0; m_vld = 0; m_lock = 0;
      pend_e.delete(); pend_t.delete();
      return;
    end
    m_vld = 0;
    if (pend_t.size() > 0 && pend_t[0] == cyc_n) begin
      e = pend_e.pop_front();
      void'(pend_t.pop_front());
`ifdef GARDNER_INTEGRATOR_EN
      m_integ = clamp(m_integ + (e >>> ki), SAT_ACC);
`endif
      v = (e >>> kp) + m_integ;
      m_errn = clamp(-v, SAT_W);
      m_vld = 1;
    end
    if (s) begin
      if (m_state == 2 && m_midok) begin
        e = (m_im * (m_ip - longint'(d_i1)) + m_qm * (m_qp - longint'(d_q1))) >>> (WIDTH - 1);
        pend_e.push_back(e);
        pend_t.push_back(cyc_n + 3);
      end
      if (m_state == 0) m_state = 1;
      else if (m_state == 1 && m_midok) m_state = 2;
      m_ip = d_i1; m_qp = d_q1;
      if (m_cnt >= 2) m_lp = m_cnt;
      m_cnt = 1;
      m_midok = 0;
    end else begin
      if (m_cnt == m_lp / 2) begin
        m_im = d_i32; m_qm = d_q32; m_midok = 1;
      end
      if (m_cnt == CNT_MAX && m_state != 0) m_state = 0;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    m_lock = (m_state == 2);
  endtask

  task cyc(input bit s);
    bus.sym_strobe = s;
    bus.i_32m = 16'(d_i32);
    bus.q_32m = 16'(d_q32);
    bus.i_1m  = 16'(d_i1);
    bus.q_1m  = 16'(d_q1);
    model_step(s);
    @(posedge clk);
    #1;
    cyc_n++;
    check("err_valid", bus.err_valid, m_vld);
    check("error_n", longint'(bus.error_n), m_errn);
    check("locked_out", bus.locked_out, m_lock);
    if (bus.err_valid) vld_count++;
  endtask

  task do_reset();
    rst = 1'b1;
    repeat (5) cyc(1'b0);
    rst = 1'b0;
  endtask

  // n-1 idle cycles then a strobe carrying (i1, q1)
  task period(input int n, input int i1, input int q1);
    repeat (n - 1) cyc(1'b0);
    d_i1 = i1; d_q1 = q1;
    cyc(1'b1);
  endtask

  typedef struct {
    int ip, ic, im, qp, qc, qm;
    int kp, ki;
    int exp_int, exp_noint;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int x, gap;
    longint last, exp;

    vecs[0] = '{8000, 8000, 0, 0, 0, 0, 0, 15, 0, 0};
    vecs[1] = '{16384, -16384, 16384, 0, 0, 0, 2, 15, -4096, -4096};
    vecs[2] = '{0, 0, 0, 16384, -16384, -16384, 2, 15, 4097, 4096};
    vecs[3] = '{32767, -32768, 32767, 32767, -32768, 32767, 0, 15, -32767, -32767};
    vecs[4] = '{32767, -32768, -32768, 32767, -32768, -32768, 0, 15, 32767, 32767};
    vecs[5] = '{2, 0, 16384, 0, 0, 0, 0, 15, -1, -1};
    vecs[6] = '{0, 1, 1, 0, 0, 0, 0, 15, 2, 1};

    for (int v = 0; v < 7; v++) begin
      do_reset();
      check("rst_error_n", longint'(bus.error_n), 0);
      check("rst_err_valid", bus.err_valid, 0);
      check("rst_locked", bus.locked_out, 0);
      kp = 4'(vecs[v].kp); ki = 4'(vecs[v].ki);
      d_i32 = vecs[v].im; d_q32 = vecs[v].qm;
      period(4, 0, 0);
      check("prime_unlocked", bus.locked_out, 0);
      period(32, vecs[v].ip, vecs[v].qp);
      check("run_locked", bus.locked_out, 1);
      period(32, vecs[v].ic, vecs[v].qc);
      repeat (3) cyc(1'b0);
      check("vec_valid", bus.err_valid, 1);
`ifdef GARDNER_INTEGRATOR_EN
      check("vec_error_n", longint'(bus.error_n), vecs[v].exp_int);
`else
      check("vec_error_n", longint'(bus.error_n), vecs[v].exp_noint);
`endif
    end

    // Integrator ramp with constant e=+16384, proportional path shifted out
    do_reset();
    kp = 4'd15; ki = 4'd4;
    d_q32 = 0;
    x = 16384;
    d_i32 = 0;
    period(4, x, 0);
    d_i32 = x; x = -x;
    period(32, x, 0);
    repeat (3) cyc(1'b0);
    last = 0;
    for (int k = 1; k <= 40; k++) begin
      d_i32 = x; x = -x;
      repeat (28) cyc(1'b0);
      d_i1 = x;
      cyc(1'b1);
      repeat (3) cyc(1'b0);
`ifdef GARDNER_INTEGRATOR_EN
      exp = (-1024 * k < -32767) ? -32767 : -1024 * k;
`else
      exp = 0;
`endif
      check("ramp_valid", bus.err_valid, 1);
      check("ramp_error_n", longint'(bus.error_n), exp);
      last = exp;
    end

    // Timeout then re-lock
    repeat (70) cyc(1'b0);
    check("timeout_unlocked", bus.locked_out, 0);
    check("timeout_hold", longint'(bus.error_n), last);
    d_i32 = 10000;
    period(32, 8000, 0);
    check("relock_prime", bus.locked_out, 0);
    period(32, 8000, 0);
    check("relock_run", bus.locked_out, 1);

    // Back-to-back strobes, reset lands at S+2 of the second
    kp = 4'd0;
    vld_count = 0;
    period(32, -8000, 0);
    cyc(1'b0); cyc(1'b0);
    d_i1 = 3000;
    cyc(1'b1);
    cyc(1'b0);
    rst = 1'b1;
    cyc(1'b0);
    check("b2b_one_valid", vld_count, 1);
    cyc(1'b0);
    rst = 1'b0;
    vld_count = 0;
    repeat (12) cyc(1'b0);
    check("b2b_none_after_rst", vld_count, 0);
    check("b2b_rst_error_n", longint'(bus.error_n), 0);
    check("b2b_rst_locked", bus.locked_out, 0);

    // Random strobe spacing, samples, gains and occasional resets
    do_reset();
    for (int n = 0; n < 150; n++) begin
      kp = 4'($urandom_range(0, 15));
      ki = 4'($urandom_range(0, 15));
      gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 80)) : int'($urandom_range(3, 40));
      for (int g = 0; g < gap - 1; g++) begin
        d_i32 = int'($urandom_range(0, 65535)) - 32768;
        d_q32 = int'($urandom_range(0, 65535)) - 32768;
        rst = ($urandom_range(0, 399) == 0);
        cyc(1'b0);
      end
      rst = 1'b0;
      d_i1 = int'($urandom_range(0, 65535)) - 32768;
      d_q1 = int'($urandom_range(0, 65535)) - 32768;
      cyc(1'b1);
    end
    repeat (8) cyc(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
